// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller. One 1-bit full adder is
// stepped over WIDTH-bit operands, LSB first, with a registered carry fed back
// between bits. One request per WIDTH+2 cycles: accept, WIDTH RUN cycles, DONE.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   When defined, adds input `sub`. With sub=1 the B operand is inverted and
//   the initial carry forced to 1, so the result is x_1 - x_2 (carry_out=1
//   means no borrow). When undefined there is no sub port and no extra logic.
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset_n    in   1      asynchronous active-low reset
//   start      in   1      request, sampled only in IDLE
//   x_1, x_2   in   WIDTH  operands, captured on accepted start
//   carry_in   in   1      initial carry, captured on accepted start
//   sub        in   1      (SERIAL_ADDER_SUB_EN only) subtract select
//   busy       out  1      high while a request is in RUN
//   done       out  1      one-cycle pulse, sum/carry_out valid
//   sum        out  WIDTH  result, held until the next done
//   carry_out  out  1      final carry, held until the next done
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x_1,
    input  logic [WIDTH-1:0] x_2,
    input  logic             carry_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh, a_sh_d;
    logic [WIDTH-1:0] b_sh, b_sh_d;
    logic [WIDTH-1:0] s_sh, s_sh_d;
    logic             c_reg, c_reg_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             busy_d, done_d, carry_out_d;
    logic [WIDTH-1:0] sum_d;

    // Operand B and initial carry as loaded into the datapath
    logic [WIDTH-1:0] b_load_c;
    logic             c_load_c;
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load_c = sub ? ~x_2 : x_2;
    assign c_load_c = sub ? 1'b1 : carry_in;
`else
    assign b_load_c = x_2;
    assign c_load_c = carry_in;
`endif

    // The single 1-bit full adder cell
    logic fa_sum_c, fa_cout_c;
    assign fa_sum_c  = a_sh[0] ^ b_sh[0] ^ c_reg;
    assign fa_cout_c = (a_sh[0] & b_sh[0]) | (c_reg & (a_sh[0] ^ b_sh[0]));

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            s_sh      <= '0;
            c_reg     <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sh      <= a_sh_d;
            b_sh      <= b_sh_d;
            s_sh      <= s_sh_d;
            c_reg     <= c_reg_d;
            cnt       <= cnt_d;
            busy      <= busy_d;
            done      <= done_d;
            sum       <= sum_d;
            carry_out <= carry_out_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh;
        b_sh_d      = b_sh;
        s_sh_d      = s_sh;
        c_reg_d     = c_reg;
        cnt_d       = cnt;
        busy_d      = busy;
        done_d      = 1'b0;
        sum_d       = sum;
        carry_out_d = carry_out;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = x_1;
                    b_sh_d  = b_load_c;
                    c_reg_d = c_load_c;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_sh_d  = {fa_sum_c, s_sh[WIDTH-1:1]};
                a_sh_d  = {1'b0, a_sh[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh[WIDTH-1:1]};
                c_reg_d = fa_cout_c;
                cnt_d   = cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    // Last bit: publish the fully shifted result with the final carry
                    sum_d       = {fa_sum_c, s_sh[WIDTH-1:1]};
                    carry_out_d = fa_cout_c;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    cnt_d       = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
